// File: rtl/ih_pkg.sv
// rtl/ih_pkg.sv - shared interrupt types, controller state encoding and vector helper
package ih_pkg;

  localparam int NUM_IRQ_SRC = 4;

  typedef enum logic [1:0] {
    timer_is    = 2'd0,
    input_is    = 2'd1,
    gpio_is     = 2'd2,
    external_is = 2'd3
  } interrupt_source;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } ic_state_t;

  // 16-bit arithmetic; wraps rather than saturates
  function automatic logic [15:0] ic_vector(input logic [15:0] base,
                                            input logic [15:0] stride,
                                            input interrupt_source src);
    return base + stride * {14'b0, src};
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - request/acknowledge/return handshake between controller and core
interface interrupt_controller_if;
  import ih_pkg::*;

  logic            irq_req;
  interrupt_source irq_source;
  logic [15:0]     irq_vector;
  logic            in_service;
  logic            cpu_ack;
  logic            cpu_iret;

  modport master (
    output irq_req, irq_source, irq_vector, in_service,
    input  cpu_ack, cpu_iret
  );

  modport slave (
    input  irq_req, irq_source, irq_vector, in_service,
    output cpu_ack, cpu_iret
  );

endinterface

// File: rtl/ic_priority_select.sv
// rtl/ic_priority_select.sv - rotating-start priority search over the eligible sources
module ic_priority_select #(
  parameter int NUM = 4,
  parameter int IW  = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0] i_eligible,
  input  logic [IW-1:0]  i_start,
  output logic           o_valid,
  output logic [IW-1:0]  o_winner
);

  int w_idx;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NUM; k++) begin
      w_idx = (int'(i_start) + k) % NUM;
      if (!o_valid && i_eligible[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending latch, arbitration and core handshake FSM
// IC_ROUND_ROBIN_EN selects rotating priority; undefined gives fixed lowest-index-first.
module interrupt_controller
  import ih_pkg::*;
#(
  parameter int          NUM_SRC       = NUM_IRQ_SRC,
  parameter logic [15:0] VECTOR_BASE   = 16'h0100,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0010,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_SRC-1:0]  src_fire,
  input  logic [NUM_SRC-1:0]  src_enable,
  input  logic                global_enable,
  input  logic                lost_clear,
  output logic [NUM_SRC-1:0]  pending,
  output logic [NUM_SRC-1:0]  lost,
  output logic                ack_timeout,
  interrupt_controller_if.master io_core
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  ic_state_t         r_state;
  logic              r_irq_req;
  logic              r_in_service;
  interrupt_source   r_irq_source;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_lost;
  logic              r_ack_timeout;
  logic [TW-1:0]     r_to_cnt;

  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [NUM_SRC-1:0] w_lost_nxt;
  logic [IW-1:0]     w_start;
  logic [IW-1:0]     w_winner;
  logic              w_valid;
  logic              w_ack_take;
  logic              w_timeout_hit;
  logic              w_withdraw;

`ifdef IC_ROUND_ROBIN_EN
  logic [IW-1:0]     r_last_ack;
  assign w_start = (r_last_ack == IW'(NUM_SRC - 1)) ? '0 : r_last_ack + IW'(1);
`else
  assign w_start = '0;
`endif

  assign w_eligible    = r_pending & src_enable & {NUM_SRC{global_enable}};
  assign w_ack_take    = (r_state == REQ) && io_core.cpu_ack;
  assign w_timeout_hit = (ACK_TIMEOUT != 0) && (r_to_cnt == TO_LAST);
  assign w_withdraw    = w_timeout_hit || !global_enable || !src_enable[r_irq_source];

  ic_priority_select #(.NUM(NUM_SRC), .IW(IW)) u_select (
    .i_eligible (w_eligible),
    .i_start    (w_start),
    .o_valid    (w_valid),
    .o_winner   (w_winner)
  );

  // A new fire on the source being acknowledged re-arms it instead of counting as lost
  always_comb begin
    w_set = src_fire & src_enable;
    w_clr = '0;
    if (w_ack_take) w_clr[r_irq_source] = 1'b1;
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
    w_lost_nxt    = (lost_clear ? '0 : r_lost) | (w_set & r_pending & ~w_clr);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= IDLE;
      r_irq_req     <= 1'b0;
      r_in_service  <= 1'b0;
      r_irq_source  <= timer_is;
      r_pending     <= '0;
      r_lost        <= '0;
      r_ack_timeout <= 1'b0;
      r_to_cnt      <= '0;
`ifdef IC_ROUND_ROBIN_EN
      r_last_ack    <= IW'(NUM_SRC - 1);
`endif
    end else begin
      r_pending <= w_pending_nxt;
      r_lost    <= w_lost_nxt;
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_valid) begin
            r_irq_source <= interrupt_source'(w_winner);
            r_irq_req    <= 1'b1;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (io_core.cpu_ack) begin
            r_irq_req    <= 1'b0;
            r_in_service <= 1'b1;
            r_to_cnt     <= '0;
            r_state      <= SERVICE;
`ifdef IC_ROUND_ROBIN_EN
            r_last_ack   <= IW'(r_irq_source);
`endif
          end else if (w_withdraw) begin
            if (w_timeout_hit) r_ack_timeout <= 1'b1;
            r_irq_req <= 1'b0;
            r_to_cnt  <= '0;
            r_state   <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        SERVICE: begin
          if (io_core.cpu_iret) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_irq_req    <= 1'b0;
          r_in_service <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign io_core.irq_req    = r_irq_req;
  assign io_core.irq_source = r_irq_source;
  assign io_core.irq_vector = ic_vector(VECTOR_BASE, VECTOR_STRIDE, r_irq_source);
  assign io_core.in_service = r_in_service;
  assign pending            = r_pending;
  assign lost               = r_lost;
  assign ack_timeout        = r_ack_timeout;

endmodule
